clock_div_monitor: RTL and testbench

Receiving end of the divided clock/reset pair produced by the team's even-integer clock divider. It samples the divided clock and reset as data in the source clock domain, synchronizes them, and emits single-cycle rise/fall clock enables so logic can stay on the source clock. It also measures each half-period, checks it against the expected divisor, and reports lock, stall and reset-sequence errors. It is used by bring-up logic and as a bench checker.

---
 rtl/clock_div_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_clock_div_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_monitor.sv
// clock_div_monitor
// Receives the divided clock/reset pair from the even-integer clock divider.
// Both are sampled as data on i_clk_mhz and synchronized. Single-cycle
// rise/fall enables are produced from them. Each half-period is measured
// against the expected divisor, and lock, stall and reset-sequence status
// is reported.

module clock_div_monitor #(
    parameter int par_clk_divisor = 1000,
    parameter int par_tol         = 1,
    parameter int par_lock_count  = 4,
    parameter int par_sync_stages = 2,
    parameter int par_cnt_width   = 16
) (
    input  logic                     i_clk_mhz,
    input  logic                     i_rstn_mhz,
    input  logic                     i_clk_div,
    input  logic                     i_rst_div,
    output logic                     o_rise_ce,
    output logic                     o_fall_ce,
    output logic                     o_locked,
    output logic                     o_stall,
    output logic                     o_err_pulse,
    output logic                     o_rst_err,
    output logic                     o_rst_done,
    output logic [par_cnt_width-1:0] o_half_meas,
    output logic [7:0]               o_err_cnt
);

    localparam int c_half   = par_clk_divisor / 2;
    localparam int c_good_w = $clog2(par_lock_count + 1);

    localparam logic [par_cnt_width-1:0] c_lo      = par_cnt_width'(c_half - par_tol);
    localparam logic [par_cnt_width-1:0] c_hi      = par_cnt_width'(c_half + par_tol);
    localparam logic [par_cnt_width-1:0] c_stall   = par_cnt_width'(c_half + par_tol + 1);
    localparam logic [par_cnt_width-1:0] c_cnt_one = par_cnt_width'(1);
    localparam logic [c_good_w-1:0]      c_good_one    = c_good_w'(1);
    localparam logic [c_good_w-1:0]      c_lock_target = c_good_w'(par_lock_count);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_STALLED
    } state_t;

    // Synchronizer chains: bit 0 samples the input, the top bit is the synchronized level
    logic [par_sync_stages-1:0] clk_sync_reg;
    logic [par_sync_stages-1:0] rst_sync_reg;
    logic                       clk_s;
    logic                       rst_s;

    // Edge detection state and registered strobes
    logic clk_prev_reg;
    logic rst_prev_reg;
    logic rise_ce_reg;
    logic fall_ce_reg;
    logic rst_done_reg;
    logic rst_err_reg;

    logic clk_rise_det;
    logic clk_fall_det;
    logic rst_fall_det;
    logic edge_det;

    // Measurement and FSM state
    state_t                    state_reg;
    logic [par_cnt_width-1:0]  cnt_reg;
    logic [par_cnt_width-1:0]  cnt_inc;
    logic                      meas_good;
    logic [c_good_w-1:0]       good_reg;
    logic [par_cnt_width-1:0]  half_meas_reg;
    logic                      err_pulse_reg;
    logic [7:0]                err_cnt_reg;
    logic                      locked_reg;
    logic                      stall_reg;

    assign clk_s = clk_sync_reg[par_sync_stages-1];
    assign rst_s = rst_sync_reg[par_sync_stages-1];

    assign clk_rise_det = clk_s & ~clk_prev_reg;
    assign clk_fall_det = ~clk_s & clk_prev_reg;
    assign rst_fall_det = ~rst_s & rst_prev_reg;
    assign edge_det     = clk_rise_det | clk_fall_det;

    // The measurement is the spacing between edge strobes, i.e. the count value plus one
    assign cnt_inc   = (&cnt_reg) ? cnt_reg : (cnt_reg + c_cnt_one);
    assign meas_good = (cnt_inc >= c_lo) && (cnt_inc <= c_hi);

    // Shift the divided clock and reset through their synchronizer chains
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            clk_sync_reg <= '0;
            rst_sync_reg <= '0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[par_sync_stages-2:0], i_clk_div};
            rst_sync_reg <= {rst_sync_reg[par_sync_stages-2:0], i_rst_div};
        end
    end

    // Register edge strobes and classify reset deassertion against the clock falling edge
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            clk_prev_reg <= 1'b0;
            rst_prev_reg <= 1'b0;
            rise_ce_reg  <= 1'b0;
            fall_ce_reg  <= 1'b0;
            rst_done_reg <= 1'b0;
            rst_err_reg  <= 1'b0;
        end else begin
            clk_prev_reg <= clk_s;
            rst_prev_reg <= rst_s;
            rise_ce_reg  <= clk_rise_det;
            fall_ce_reg  <= clk_fall_det;
            rst_done_reg <= rst_fall_det & clk_fall_det;
            rst_err_reg  <= rst_fall_det & ~clk_fall_det;
        end
    end

    // Half-period counter, lock/stall FSM, measurement capture and error counting
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            good_reg      <= '0;
            half_meas_reg <= '0;
            err_pulse_reg <= 1'b0;
            err_cnt_reg   <= '0;
            locked_reg    <= 1'b0;
            stall_reg     <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            cnt_reg       <= edge_det ? '0 : cnt_inc;

            if (rst_s) begin
                // Divided-domain reset overrides everything; measurement and error count hold
                state_reg  <= ST_IDLE;
                cnt_reg    <= '0;
                good_reg   <= '0;
                locked_reg <= 1'b0;
                stall_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // First edge after reset only starts the counter
                        if (edge_det) begin
                            state_reg <= ST_ACQUIRE;
                            good_reg  <= '0;
                        end
                    end

                    ST_ACQUIRE: begin
                        if (edge_det) begin
                            half_meas_reg <= cnt_inc;
                            if (meas_good) begin
                                if ((good_reg + c_good_one) == c_lock_target) begin
                                    state_reg  <= ST_LOCKED;
                                    locked_reg <= 1'b1;
                                end
                                good_reg <= good_reg + c_good_one;
                            end else begin
                                good_reg      <= '0;
                                err_pulse_reg <= 1'b1;
                                if (err_cnt_reg != 8'hFF) begin
                                    err_cnt_reg <= err_cnt_reg + 8'd1;
                                end
                            end
                        end else if (cnt_inc >= c_stall) begin
                            state_reg <= ST_STALLED;
                            stall_reg <= 1'b1;
                            good_reg  <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        if (edge_det) begin
                            half_meas_reg <= cnt_inc;
                            if (!meas_good) begin
                                state_reg     <= ST_ACQUIRE;
                                locked_reg    <= 1'b0;
                                good_reg      <= '0;
                                err_pulse_reg <= 1'b1;
                                if (err_cnt_reg != 8'hFF) begin
                                    err_cnt_reg <= err_cnt_reg + 8'd1;
                                end
                            end
                        end else if (cnt_inc >= c_stall) begin
                            state_reg  <= ST_STALLED;
                            locked_reg <= 1'b0;
                            stall_reg  <= 1'b1;
                            good_reg   <= '0;
                        end
                    end

                    ST_STALLED: begin
                        // The edge ending a stall is not measured; it only restarts the counter
                        if (edge_det) begin
                            state_reg <= ST_ACQUIRE;
                            stall_reg <= 1'b0;
                            good_reg  <= '0;
                        end
                    end

                    default: begin
                        state_reg  <= ST_IDLE;
                        locked_reg <= 1'b0;
                        stall_reg  <= 1'b0;
                        good_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_rise_ce   = rise_ce_reg;
    assign o_fall_ce   = fall_ce_reg;
    assign o_locked    = locked_reg;
    assign o_stall     = stall_reg;
    assign o_err_pulse = err_pulse_reg;
    assign o_rst_err   = rst_err_reg;
    assign o_rst_done  = rst_done_reg;
    assign o_half_meas = half_meas_reg;
    assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Bench for clock_div_monitor: drives a divided clock/reset pair with chosen
// half-periods and checks every edge strobe against a queue of expectations
// pushed when that edge was driven.

module tb_clock_div_monitor;

    logic        i_clk_mhz  = 1'b0;
    logic        i_rstn_mhz = 1'b0;
    logic        i_clk_div  = 1'b0;
    logic        i_rst_div  = 1'b1;
    logic        o_rise_ce;
    logic        o_fall_ce;
    logic        o_locked;
    logic        o_stall;
    logic        o_err_pulse;
    logic        o_rst_err;
    logic        o_rst_done;
    logic [15:0] o_half_meas;
    logic [7:0]  o_err_cnt;

    clock_div_monitor #(
        .par_clk_divisor (1000),
        .par_tol         (1),
        .par_lock_count  (4),
        .par_sync_stages (2),
        .par_cnt_width   (16)
    ) dut (
        .i_clk_mhz   (i_clk_mhz),
        .i_rstn_mhz  (i_rstn_mhz),
        .i_clk_div   (i_clk_div),
        .i_rst_div   (i_rst_div),
        .o_rise_ce   (o_rise_ce),
        .o_fall_ce   (o_fall_ce),
        .o_locked    (o_locked),
        .o_stall     (o_stall),
        .o_err_pulse (o_err_pulse),
        .o_rst_err   (o_rst_err),
        .o_rst_done  (o_rst_done),
        .o_half_meas (o_half_meas),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 i_clk_mhz = ~i_clk_mhz;

    int cyc = 0;
    always @(posedge i_clk_mhz) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    typedef struct {
        bit rise;
        int cyc;
        int meas;
        bit err;
        bit locked;
    } edge_exp_t;

    edge_exp_t exp_q[$];
    edge_exp_t mon_e;

    int last_toggle    = 0;
    int last_pulse_cyc = 0;
    int stall_rise_cyc = -1;
    int rst_err_cyc    = -1;
    int rst_done_seen  = 0;
    int rst_err_seen   = 0;
    bit stall_prev     = 1'b0;

    // Wait until just after the posedge on which cyc reaches target
    task automatic wait_until(input int target);
        do begin
            @(posedge i_clk_mhz);
            #1;
        end while (cyc < target);
    endtask

    // Toggle i_clk_div h cycles after the previous toggle and queue what its strobe must show
    task automatic half(input int h, input bit rst_val, input int meas, input bit err, input bit locked);
        edge_exp_t e;
        wait_until(last_toggle + h);
        i_clk_div   = ~i_clk_div;
        i_rst_div   = rst_val;
        last_toggle = cyc;
        e.rise   = i_clk_div;
        e.cyc    = cyc + 3;
        e.meas   = meas;
        e.err    = err;
        e.locked = locked;
        exp_q.push_back(e);
        $display("drive: %s at cycle %0d half=%0d rst_div=%0d", e.rise ? "rise" : "fall", cyc, h, rst_val);
    endtask

    // Monitor: pop and compare an expectation on every edge strobe
    always @(negedge i_clk_mhz) begin
        if (o_rise_ce || o_fall_ce) begin
            last_pulse_cyc = cyc;
            if (o_rise_ce && o_fall_ce) check_val("rise_fall_overlap", int'(o_rise_ce & o_fall_ce), 0);
            if (exp_q.size() == 0) begin
                check_val("edge_pulse_expected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("edge_dir", int'(o_rise_ce), int'(mon_e.rise));
                check_val("edge_cycle", cyc, mon_e.cyc);
                check_val("half_meas", int'(o_half_meas), mon_e.meas);
                check_val("err_pulse", int'(o_err_pulse), int'(mon_e.err));
                check_val("locked", int'(o_locked), int'(mon_e.locked));
                check_val("stall_at_edge", int'(o_stall), 0);
                $display("edge: %s cycle=%0d meas=%0d err=%0d locked=%0d err_cnt=%0d",
                         o_rise_ce ? "rise" : "fall", cyc, o_half_meas, o_err_pulse, o_locked, o_err_cnt);
            end
        end else if (o_err_pulse) begin
            check_val("stray_err_pulse", int'(o_err_pulse), 0);
        end
        if (o_rst_done) begin
            rst_done_seen++;
            check_val("rst_done_on_fall", int'(o_fall_ce), 1);
        end
        if (o_rst_err) begin
            rst_err_seen++;
            rst_err_cyc = cyc;
        end
        if (o_stall && !stall_prev) stall_rise_cyc = cyc;
        stall_prev = o_stall;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset held while the divided clock toggles: nothing may come out
        repeat (2) @(posedge i_clk_mhz);
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(posedge i_clk_mhz);
            #1;
            i_clk_div = ~i_clk_div;
        end
        repeat (4) @(posedge i_clk_mhz);
        @(negedge i_clk_mhz);
        check_val("rst_rise_ce", int'(o_rise_ce), 0);
        check_val("rst_fall_ce", int'(o_fall_ce), 0);
        check_val("rst_locked", int'(o_locked), 0);
        check_val("rst_stall", int'(o_stall), 0);
        check_val("rst_err_pulse", int'(o_err_pulse), 0);
        check_val("rst_rst_done", int'(o_rst_done), 0);
        check_val("rst_rst_err", int'(o_rst_err), 0);
        check_val("rst_half_meas", int'(o_half_meas), 0);
        check_val("rst_err_cnt", int'(o_err_cnt), 0);

        @(posedge i_clk_mhz);
        #1;
        i_rstn_mhz  = 1'b1;
        last_toggle = cyc;

        // Rise while rst_div held, then legal deassertion with the falling edge
        half(5, 1'b1, 0, 1'b0, 1'b0);
        half(500, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) half(500, 1'b0, 500, 1'b0, i == 3);
        half(500, 1'b0, 500, 1'b0, 1'b1);
        wait_until(last_toggle + 20);
        check_val("lock_rst_done_count", rst_done_seen, 1);
        check_val("lock_rst_err_count", rst_err_seen, 0);
        check_val("lock_err_cnt", int'(o_err_cnt), 0);
        check_val("lock_locked", int'(o_locked), 1);

        // One long half-period breaks lock, four at the tolerance edge relock
        half(500, 1'b0, 500, 1'b0, 1'b1);
        half(502, 1'b0, 502, 1'b1, 1'b0);
        wait_until(last_toggle + 20);
        check_val("tol_err_cnt", int'(o_err_cnt), 1);
        for (int i = 0; i < 4; i++) half(501, 1'b0, 501, 1'b0, i == 3);
        half(500, 1'b0, 500, 1'b0, 1'b1);

        // Freeze high while locked: stall 502 cycles after the last strobe
        half(500, 1'b0, 500, 1'b0, 1'b1);
        wait_until(last_toggle + 600);
        @(negedge i_clk_mhz);
        check_val("stall_delay", stall_rise_cyc - last_pulse_cyc, 502);
        check_val("stall_asserted", int'(o_stall), 1);
        check_val("stall_unlocked", int'(o_locked), 0);
        half(700, 1'b0, 500, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) half(500, 1'b0, 500, 1'b0, i == 3);

        // Mid-run divided reset while locked
        wait_until(last_toggle + 200);
        i_rst_div = 1'b1;
        n = cyc;
        wait_until(n + 2);
        @(negedge i_clk_mhz);
        check_val("midrst_locked_before", int'(o_locked), 1);
        @(negedge i_clk_mhz);
        check_val("midrst_locked_after", int'(o_locked), 0);
        check_val("midrst_half_meas", int'(o_half_meas), 500);
        check_val("midrst_err_cnt", int'(o_err_cnt), 1);
        half(500, 1'b1, 500, 1'b0, 1'b0);

        // Illegal deassertion in the middle of the high phase
        wait_until(last_toggle + 200);
        i_rst_div = 1'b0;
        n = cyc;
        half(500, 1'b0, 500, 1'b0, 1'b0);
        half(500, 1'b0, 500, 1'b0, 1'b0);
        half(500, 1'b0, 500, 1'b0, 1'b0);
        wait_until(last_toggle + 20);
        check_val("badrst_err_count", rst_err_seen, 1);
        check_val("badrst_err_cycle", rst_err_cyc, n + 3);
        check_val("badrst_done_count", rst_done_seen, 1);
        check_val("final_err_cnt", int'(o_err_cnt), 1);
        check_val("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
